// File: rtl/jtag_boot_pkg.sv
// Shared types for the JTAG boot master: opcodes, FSM states, default shift width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_boot_pkg;

   localparam int MAX_LEN_DEFAULT = 64;

   // TCK periods spent in each fixed phase of a TAP reset
   localparam logic [6:0] TRST_PERIODS     = 7'd4;
   localparam logic [6:0] TLR_TMS1_PERIODS = 7'd5;

   typedef enum logic [1:0] {
      OP_TAP_RESET = 2'd0,
      OP_SHIFT_IR  = 2'd1,
      OP_SHIFT_DR  = 2'd2,
      OP_RUN_IDLE  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TRST     = 3'd1,
      ST_TLR      = 3'd2,
      ST_WALK_IN  = 3'd3,
      ST_SHIFT    = 3'd4,
      ST_WALK_OUT = 3'd5,
      ST_RUN      = 3'd6,
      ST_DONE     = 3'd7
   } state_e;

   // Run-Test/Idle -> Shift-IR is 1,1,0,0; Run-Test/Idle -> Shift-DR is 1,0,0
   function automatic logic [6:0] walk_len(input op_e op);
      return (op == OP_SHIFT_IR) ? 7'd4 : 7'd3;
   endfunction

   function automatic logic walk_tms(input op_e op, input logic [6:0] idx);
      return (op == OP_SHIFT_IR) ? (idx < 7'd2) : (idx < 7'd1);
   endfunction

endpackage

// File: rtl/jtag_boot_master_tck_gen.sv
// TCK divider: CLK_DIV s_clk cycles per half-period, TCK parked low while disabled.
// Latency: first rise CLK_DIV cycles after enable; strobes are combinational, one cycle wide.
// Backpressure: none; runs freely whenever en is high.
module jtag_tck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic s_clk,
   input  logic s_rst_n,
   input  logic en,
   output logic tck,
   output logic rise_stb,
   output logic fall_stb
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_q, div_d;
   logic       tck_q, tck_d;
   logic       half_done;

   assign half_done = en && (div_q == DIV_LAST);
   assign rise_stb  = half_done && !tck_q;
   assign fall_stb  = half_done && tck_q;
   assign tck       = tck_q;

   // Divider count and TCK toggle; disabling clears both so every command starts from phase 0
   always_comb begin
      div_d = div_q;
      tck_d = tck_q;
      if (!en) begin
         div_d = 8'd0;
         tck_d = 1'b0;
      end else if (half_done) begin
         div_d = 8'd0;
         tck_d = !tck_q;
      end else begin
         div_d = div_q + 8'd1;
      end
   end

   // Divider state registers
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         div_q <= 8'd0;
         tck_q <= 1'b0;
      end else begin
         div_q <= div_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/jtag_boot_master.sv
// Command-driven JTAG master: TAP reset, IR/DR shifts and idle clocking toward pulpino_top.
// Latency: busy one cycle after accept; response (2*CLK_DIV * TCK periods) + 1 cycles later.
// Backpressure: cmd_ready_o low while busy; requests during that time are dropped, not queued.
module jtag_boot_master
   import jtag_boot_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic               s_clk,
   input  logic               s_rst_n,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_op_i,
   input  logic [6:0]         cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   output logic               rsp_err_o,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               busy_o,
   output logic               tck_o,
   output logic               trstn_o,
   output logic               tms_o,
   output logic               tdi_o,
   input  logic               tdo_i
);

   localparam logic [7:0] MAX_LEN_8 = 8'(MAX_LEN);
   localparam logic [6:0] MAX_LEN_7 = 7'(MAX_LEN);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [6:0]         len_q, len_d;
   logic [6:0]         cnt_q, cnt_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] cap_q, cap_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               trstn_q, trstn_d;
   logic               rise_stb, fall_stb;
   logic               last_bit, len_bad;

   assign busy_o      = (state_q != ST_IDLE);
   assign cmd_ready_o = !busy_o;
   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_err_o   = rsp_err_q;
   assign rsp_data_o  = rsp_data_q;
   assign tms_o       = tms_q;
   assign tdi_o       = tdi_q;
   assign trstn_o     = trstn_q;
   assign last_bit    = (cnt_q == len_q - 7'd1);
   assign len_bad     = (cmd_len_i == 7'd0) || ({1'b0, cmd_len_i} > MAX_LEN_8);

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .s_clk    (s_clk),
      .s_rst_n  (s_rst_n),
      .en       (busy_o),
      .tck      (tck_o),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // Sequencer: pins change only at TCK falls (or at accept), TDO is captured at TCK rises
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      cap_d      = cap_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      tms_d      = tms_q;
      tdi_d      = tdi_q;
      trstn_d    = trstn_q;
      case (state_q)
         ST_IDLE: if (cmd_valid_i) begin
            op_d   = op_e'(cmd_op_i);
            len_d  = cmd_len_i;
            data_d = cmd_data_i;
            cnt_d  = 7'd0;
            cap_d  = '0;
            tdi_d  = 1'b0;
            case (op_e'(cmd_op_i))
               OP_TAP_RESET: begin
                  state_d = ST_TRST;
                  trstn_d = 1'b0;
                  tms_d   = 1'b1;
               end
               OP_SHIFT_IR, OP_SHIFT_DR: begin
                  if (len_bad) begin
                     state_d    = ST_DONE;
                     rsp_err_d  = 1'b1;
                     rsp_data_d = '0;
                  end else begin
                     state_d = ST_WALK_IN;
                     tms_d   = 1'b1;
                  end
               end
               default: begin
                  if (cmd_len_i == 7'd0) begin
                     state_d    = ST_DONE;
                     rsp_err_d  = 1'b0;
                     rsp_data_d = '0;
                  end else begin
                     state_d = ST_RUN;
                     tms_d   = 1'b0;
                  end
               end
            endcase
         end
         ST_TRST: if (fall_stb) begin
            if (cnt_q == TRST_PERIODS - 7'd1) begin
               state_d = ST_TLR;
               cnt_d   = 7'd0;
               trstn_d = 1'b1;
               tms_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         // Five TMS=1 periods, then one TMS=0 period to park in Run-Test/Idle
         ST_TLR: if (fall_stb) begin
            if (cnt_q == TLR_TMS1_PERIODS) begin
               state_d    = ST_DONE;
               rsp_err_d  = 1'b0;
               rsp_data_d = '0;
            end else begin
               cnt_d = cnt_q + 7'd1;
               tms_d = (cnt_q + 7'd1 < TLR_TMS1_PERIODS);
            end
         end
         ST_WALK_IN: if (fall_stb) begin
            if (cnt_q == walk_len(op_q) - 7'd1) begin
               state_d = ST_SHIFT;
               cnt_d   = 7'd0;
               tms_d   = (len_q == 7'd1);
               tdi_d   = data_q[0];
            end else begin
               cnt_d = cnt_q + 7'd1;
               tms_d = walk_tms(op_q, cnt_q + 7'd1);
            end
         end
         // TDO enters at the top; after len bits the result is right-aligned at completion
         ST_SHIFT: begin
            if (rise_stb) begin
               cap_d = {tdo_i, cap_q[MAX_LEN-1:1]};
            end
            if (fall_stb) begin
               if (last_bit) begin
                  state_d = ST_WALK_OUT;
                  cnt_d   = 7'd0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
               end else begin
                  cnt_d  = cnt_q + 7'd1;
                  data_d = data_q >> 1;
                  tdi_d  = data_q[1];
                  tms_d  = (cnt_q + 7'd2 == len_q);
               end
            end
         end
         ST_WALK_OUT: if (fall_stb) begin
            if (cnt_q == 7'd0) begin
               cnt_d = 7'd1;
               tms_d = 1'b0;
            end else begin
               state_d    = ST_DONE;
               rsp_err_d  = 1'b0;
               rsp_data_d = cap_q >> (MAX_LEN_7 - len_q);
            end
         end
         ST_RUN: if (fall_stb) begin
            if (last_bit) begin
               state_d    = ST_DONE;
               rsp_err_d  = 1'b0;
               rsp_data_d = '0;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset drops any command in flight and leaves TRSTn asserted
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_TAP_RESET;
         len_q      <= 7'd0;
         cnt_q      <= 7'd0;
         data_q     <= '0;
         cap_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         tms_q      <= 1'b1;
         tdi_q      <= 1'b0;
         trstn_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         cap_q      <= cap_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         tms_q      <= tms_d;
         tdi_q      <= tdi_d;
         trstn_q    <= trstn_d;
      end
   end

endmodule
